// File: rtl/i2lbs_window_scheduler.sv
// Streams camera pixels into the line-buffer memory and stalls the camera while each resident window is classified.
// Optional WINDOW_STRIDE2_EN: only windows with even top-left coordinates are issued.
module i2lbs_window_scheduler #(
  parameter int DATA_WIDTH_12       = 12,
  parameter int DATA_WIDTH_16       = 16,
  parameter int INTEGRAL_WIDTH      = 3,
  parameter int INTEGRAL_HEIGHT     = 3,
  parameter int FRAME_CAMERA_WIDTH  = 10,
  parameter int FRAME_CAMERA_HEIGHT = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_frame_start,
  input  logic                     i_pixel_valid,
  input  logic [DATA_WIDTH_16-1:0] i_pixel,
  output logic                     o_pixel_ready,
  output logic                     o_mem_wen,
  output logic [DATA_WIDTH_16-1:0] o_mem_pixel,
  output logic                     o_window_valid,
  output logic [DATA_WIDTH_12-1:0] o_window_x,
  output logic [DATA_WIDTH_12-1:0] o_window_y,
  input  logic                     i_classify_done,
  output logic                     o_frame_done,
  output logic                     o_busy
);

  localparam logic [DATA_WIDTH_12-1:0] LP_X_MAX = DATA_WIDTH_12'(FRAME_CAMERA_WIDTH - 1);
  localparam logic [DATA_WIDTH_12-1:0] LP_Y_MAX = DATA_WIDTH_12'(FRAME_CAMERA_HEIGHT - 1);
  localparam logic [DATA_WIDTH_12-1:0] LP_X_OFS = DATA_WIDTH_12'(INTEGRAL_WIDTH - 1);
  localparam logic [DATA_WIDTH_12-1:0] LP_Y_OFS = DATA_WIDTH_12'(INTEGRAL_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_CLASSIFY, S_FRAME_DONE} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [DATA_WIDTH_12-1:0]   r_x;
  logic [DATA_WIDTH_12-1:0]   r_y;
  logic                       r_last;
  logic                       r_mem_wen;
  logic [DATA_WIDTH_16-1:0]   r_mem_pixel;
  logic [DATA_WIDTH_12-1:0]   r_win_x;
  logic [DATA_WIDTH_12-1:0]   r_win_y;

  logic                       w_accept;
  logic                       w_x_last;
  logic                       w_y_last;
  logic                       w_qualify;
  logic                       w_issue;
  logic [DATA_WIDTH_12-1:0]   w_win_x;
  logic [DATA_WIDTH_12-1:0]   w_win_y;

  // Frame start always wins over a pixel presented in the same cycle.
  assign w_accept  = i_pixel_valid && (r_state == S_STREAM) && !i_frame_start;
  assign w_x_last  = (r_x == LP_X_MAX);
  assign w_y_last  = (r_y == LP_Y_MAX);
  assign w_qualify = (r_x >= LP_X_OFS) && (r_y >= LP_Y_OFS);
  assign w_win_x   = r_x - LP_X_OFS;
  assign w_win_y   = r_y - LP_Y_OFS;

`ifdef WINDOW_STRIDE2_EN
  assign w_issue = w_qualify && !w_win_x[0] && !w_win_y[0];
`else
  assign w_issue = w_qualify;
`endif

  always_comb begin
    w_next = r_state;
    if (i_frame_start) begin
      w_next = S_STREAM;
    end else begin
      case (r_state)
        S_STREAM: begin
          if (w_accept) begin
            if (w_issue)                  w_next = S_WAIT_CLASSIFY;
            else if (w_x_last && w_y_last) w_next = S_FRAME_DONE;
          end
        end
        S_WAIT_CLASSIFY: begin
          if (i_classify_done) w_next = r_last ? S_FRAME_DONE : S_STREAM;
        end
        S_FRAME_DONE: w_next = S_IDLE;
        default:      w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_last <= 1'b0;
    end else if (i_frame_start) begin
      r_x    <= '0;
      r_y    <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_last <= w_x_last && w_y_last;
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_wen   <= 1'b0;
      r_mem_pixel <= '0;
      r_win_x     <= '0;
      r_win_y     <= '0;
    end else begin
      r_mem_wen <= w_accept;
      if (w_accept) r_mem_pixel <= i_pixel;
      if (w_accept && w_issue) begin
        r_win_x <= w_win_x;
        r_win_y <= w_win_y;
      end
    end
  end

  assign o_pixel_ready  = (r_state == S_STREAM) && !i_frame_start;
  assign o_mem_wen      = r_mem_wen;
  assign o_mem_pixel    = r_mem_pixel;
  assign o_window_valid = (r_state == S_WAIT_CLASSIFY);
  assign o_window_x     = r_win_x;
  assign o_window_y     = r_win_y;
  assign o_frame_done   = (r_state == S_FRAME_DONE);
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2lbs_window_scheduler.sv
// Bench for i2lbs_window_scheduler: vector table, directed corner sequences and a transaction-level frame model.
module tb_i2lbs_window_scheduler;

  localparam int FW = 10;
  localparam int FH = 10;
  localparam int NPIX = FW * FH;
`ifdef WINDOW_STRIDE2_EN
  localparam int EXP_WIN = 16;
  localparam int EXP_LAST = 6;
`else
  localparam int EXP_WIN = 64;
  localparam int EXP_LAST = 7;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_frame_start = 1'b0;
  logic        i_pixel_valid = 1'b0;
  logic [15:0] i_pixel = '0;
  logic        i_classify_done = 1'b0;
  logic        o_pixel_ready, o_mem_wen, o_window_valid, o_frame_done, o_busy;
  logic [15:0] o_mem_pixel;
  logic [11:0] o_window_x, o_window_y;

  i2lbs_window_scheduler dut (
    .clk(clk), .reset(reset), .i_frame_start(i_frame_start),
    .i_pixel_valid(i_pixel_valid), .i_pixel(i_pixel), .o_pixel_ready(o_pixel_ready),
    .o_mem_wen(o_mem_wen), .o_mem_pixel(o_mem_pixel), .o_window_valid(o_window_valid),
    .o_window_x(o_window_x), .o_window_y(o_window_y), .i_classify_done(i_classify_done),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Frame-level model: running / stalled-on-window / done-pulse flags plus accepted-pixel count.
  bit          m_run, m_win, m_fd, m_wen;
  logic [15:0] m_pix;
  int          m_cnt, m_wx, m_wy;

  int dut_nwin, dut_wen, dut_fd, last_wx, last_wy;
  bit prev_wv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit qual(input int x, input int y);
    bit q;
    q = (x >= 2) && (y >= 2);
`ifdef WINDOW_STRIDE2_EN
    q = q && ((x - 2) % 2 == 0) && ((y - 2) % 2 == 0);
`endif
    return q;
  endfunction

  task automatic model_reset();
    m_run = 0; m_win = 0; m_fd = 0; m_wen = 0; m_pix = '0;
    m_cnt = 0; m_wx = 0; m_wy = 0;
    dut_nwin = 0; dut_wen = 0; dut_fd = 0; last_wx = -1; last_wy = -1; prev_wv = 0;
  endtask

  task automatic check_regs();
    chk("mem_wen", o_mem_wen, m_wen);
    chk("mem_pixel", o_mem_pixel, m_pix);
    chk("window_valid", o_window_valid, m_win);
    chk("window_x", o_window_x, m_wx);
    chk("window_y", o_window_y, m_wy);
    chk("frame_done", o_frame_done, m_fd);
    chk("busy", o_busy, m_run || m_fd);
    if (o_mem_wen) dut_wen++;
    if (o_frame_done) dut_fd++;
    if (o_window_valid && !prev_wv) begin
      dut_nwin++; last_wx = int'(o_window_x); last_wy = int'(o_window_y);
    end
    prev_wv = o_window_valid;
  endtask

  // One clock: drive at posedge+1, check ready, advance model, check registered outputs at next posedge+1.
  task automatic cyc(input logic fs, input logic pv, input logic [15:0] pix, input logic cd);
    int x, y;
    i_frame_start = fs; i_pixel_valid = pv; i_pixel = pix; i_classify_done = cd;
    #1;
    chk("pixel_ready", o_pixel_ready, m_run && !m_win && !fs);
    m_fd = 0; m_wen = 0;
    if (fs) begin
      m_run = 1; m_win = 0; m_cnt = 0;
    end else if (m_win) begin
      if (cd) begin
        m_win = 0;
        if (m_cnt == NPIX) begin m_run = 0; m_fd = 1; end
      end
    end else if (m_run && pv) begin
      x = m_cnt % FW; y = m_cnt / FW;
      m_cnt++; m_wen = 1; m_pix = pix;
      if (qual(x, y)) begin
        m_win = 1; m_wx = x - 2; m_wy = y - 2;
      end else if (m_cnt == NPIX) begin
        m_run = 0; m_fd = 1;
      end
    end
    @(posedge clk); #1;
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b0; i_frame_start = 0; i_pixel_valid = 0; i_classify_done = 0;
    #1;
    chk("rst_ready", o_pixel_ready, 0);
    chk("rst_wen", o_mem_wen, 0);
    chk("rst_pixel", o_mem_pixel, 0);
    chk("rst_wv", o_window_valid, 0);
    chk("rst_wx", o_window_x, 0);
    chk("rst_wy", o_window_y, 0);
    chk("rst_fd", o_frame_done, 0);
    chk("rst_busy", o_busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic fs, pv; logic [15:0] pix; logic cd;
    logic e_rdy, e_wen; logic [15:0] e_mp; logic e_wv, e_busy;
  } vec_t;

  initial begin
    vec_t vt[8];
    bit   done;
    int   wcnt;
    bit   cdv;

    vt[0] = '{0, 1, 16'h1111, 0, 0, 0, 16'h0000, 0, 0};
    vt[1] = '{1, 1, 16'h2222, 0, 0, 0, 16'h0000, 0, 1};
    vt[2] = '{0, 1, 16'h0100, 0, 1, 1, 16'h0100, 0, 1};
    vt[3] = '{0, 0, 16'h3333, 0, 1, 0, 16'h0100, 0, 1};
    vt[4] = '{0, 1, 16'h0101, 0, 1, 1, 16'h0101, 0, 1};
    vt[5] = '{1, 1, 16'h4444, 0, 0, 0, 16'h0101, 0, 1};
    vt[6] = '{0, 1, 16'h0200, 1, 1, 1, 16'h0200, 0, 1};
    vt[7] = '{0, 1, 16'h0201, 1, 1, 1, 16'h0201, 0, 1};

    model_reset();
    #3;
    do_reset();

    // Vector table from idle.
    for (int i = 0; i < 8; i++) begin
      i_frame_start = vt[i].fs; i_pixel_valid = vt[i].pv; i_pixel = vt[i].pix;
      i_classify_done = vt[i].cd;
      #1;
      chk("tbl_ready", o_pixel_ready, vt[i].e_rdy);
      @(posedge clk); #1;
      chk("tbl_wen", o_mem_wen, vt[i].e_wen);
      chk("tbl_pixel", o_mem_pixel, vt[i].e_mp);
      chk("tbl_wv", o_window_valid, vt[i].e_wv);
      chk("tbl_busy", o_busy, vt[i].e_busy);
    end

    // First window after 23 pixels, then reset while stalled.
    do_reset();
    cyc(1, 0, 16'h0, 0);
    for (int i = 0; i < 23; i++) cyc(0, 1, 16'(16'h0A00 + i), 0);
    chk("first_wv", o_window_valid, 1);
    chk("first_wx", o_window_x, 0);
    chk("first_wy", o_window_y, 0);
    chk("first_wen", o_mem_wen, 1);
    cyc(0, 1, 16'h5555, 0);
    cyc(0, 1, 16'h6666, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'h7777, 0);

    // Full frame, classifier answers a few cycles after each window.
    do_reset();
    cyc(1, 0, 16'h0, 0);
    done = 0; wcnt = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      cdv  = m_win && (wcnt == 3);
      wcnt = m_win ? wcnt + 1 : 0;
      cyc(0, 1, 16'($urandom), cdv);
      if (o_frame_done) done = 1;
    end
    chk("full_finished", done, 1);
    chk("full_windows", dut_nwin, EXP_WIN);
    chk("full_last_x", last_wx, EXP_LAST);
    chk("full_last_y", last_wy, EXP_LAST);
    chk("full_wen", dut_wen, NPIX);
    cyc(0, 1, 16'h1234, 0);
    cyc(0, 1, 16'h1234, 1);
    chk("full_fd_once", dut_fd, 1);

    // Classify-done held high, random pixel gaps.
    do_reset();
    cyc(1, 0, 16'h0, 0);
    done = 0;
    for (int n = 0; n < 4000 && !done; n++) begin
      cyc(0, 1'($urandom_range(0, 1)), 16'($urandom), 1);
      if (o_frame_done) done = 1;
    end
    chk("rand_finished", done, 1);
    chk("rand_windows", dut_nwin, EXP_WIN);
    chk("rand_wen", dut_wen, NPIX);

    // Frame restart with a valid pixel at (5,4).
    do_reset();
    cyc(1, 0, 16'h0, 0);
    for (int n = 0; n < 500 && !(m_cnt == 45 && !m_win); n++)
      cyc(0, 1'($urandom_range(0, 1)), 16'($urandom), m_win);
    chk("restart_reached", m_cnt, 45);
    cyc(1, 1, 16'hDEAD, 0);
    chk("restart_nowrite", o_mem_wen, 0);
    cyc(0, 1, 16'hBEEF, 0);
    chk("restart_wen", o_mem_wen, 1);
    chk("restart_pixel", o_mem_pixel, 16'hBEEF);
    for (int i = 0; i < 30; i++) cyc(0, 1, 16'($urandom), m_win);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2lbs_window_scheduler.md
Name: i2lbs_window_scheduler

Overview:
- Sequences the camera pixel stream into the integral-image line-buffer memory and tracks the frame raster position.
- Decides when a complete INTEGRAL_WIDTH x INTEGRAL_HEIGHT window is resident in the memory. It then presents that window to the Haar classifier and stalls the camera until the classifier finishes.
- Sits between the camera interface, the line-buffer memory (drives its wen/pixel) and the classifier stage.

Parameters:
- DATA_WIDTH_12, 12, width of coordinate counters
- DATA_WIDTH_16, 16, pixel width
- INTEGRAL_WIDTH, 3, window width in pixels
- INTEGRAL_HEIGHT, 3, window height in pixels
- FRAME_CAMERA_WIDTH, 10, frame width in pixels
- FRAME_CAMERA_HEIGHT, 10, frame height in pixels

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- i_frame_start  input  1  single-cycle pulse marking the start of a new frame
- i_pixel_valid  input  1  camera pixel valid
- i_pixel  input  16  camera pixel
- o_pixel_ready  output  1  scheduler accepts a pixel this cycle
- o_mem_wen  output  1  write enable to the line-buffer memory
- o_mem_pixel  output  16  pixel to the line-buffer memory
- o_window_valid  output  1  window available to the classifier
- o_window_x  output  12  window top-left x
- o_window_y  output  12  window top-left y
- i_classify_done  input  1  classifier finished the current window
- o_frame_done  output  1  single-cycle end-of-frame pulse
- o_busy  output  1  state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, x=y=0. Every output is 0, including o_mem_pixel and the window coordinates.
- States:
  - IDLE: o_pixel_ready=0.
  - STREAM: o_pixel_ready=1.
  - WAIT_CLASSIFY: o_pixel_ready=0, o_window_valid=1.
  - FRAME_DONE: o_frame_done=1 for exactly one cycle, then IDLE.
- Frame start:
  - i_frame_start in any state clears x/y, drops o_window_valid and enters STREAM next cycle.
  - No pixel is accepted in the i_frame_start cycle, even when i_pixel_valid=1; frame start wins.
- Accept = i_pixel_valid && o_pixel_ready.
  - On accept, o_mem_wen<=1 and o_mem_pixel<=i_pixel (registered, 1-cycle latency).
  - Otherwise o_mem_wen<=0 and o_mem_pixel holds.
- Raster counters (update on accept):
  - x increments; at x=FRAME_CAMERA_WIDTH-1 it wraps to 0 and y increments.
  - Counters never exceed frame bounds.
- Window decision, using the pre-increment (x,y) of the accepted pixel:
  - Condition: x>=INTEGRAL_WIDTH-1 and y>=INTEGRAL_HEIGHT-1.
  - If met: next state WAIT_CLASSIFY; o_window_x<=x-(INTEGRAL_WIDTH-1); o_window_y<=y-(INTEGRAL_HEIGHT-1).
  - o_window_valid asserts the cycle after accept, i.e. the same cycle o_mem_wen writes the last window pixel.
- WAIT_CLASSIFY:
  - o_window_valid and the coordinates are held stable until i_classify_done=1 is sampled.
  - i_classify_done is ignored outside WAIT_CLASSIFY.
  - Exit on done: next state FRAME_DONE if the accepted pixel was (W-1,H-1), else STREAM. o_window_valid drops the same edge.
- Last pixel with no window (only possible with the optional feature): STREAM goes directly to FRAME_DONE.
- Windows per frame = (W-IW+1)*(H-IH+1).
- Counter arithmetic is unsigned 12-bit; the parameters guarantee no overflow.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: WINDOW_STRIDE2_EN.
- Defined: a window is issued only when the computed top-left x and y are both even. Other qualifying pixels stream through without stalling. The default config then yields 4*4=16 windows per frame.
- Undefined: every qualifying pixel issues a window (stride 1, 64 windows in the default config).

Test Plan:
- Reset mid-WAIT_CLASSIFY (reset=0) -> all outputs 0 immediately. After release, state IDLE and o_pixel_ready=0 until i_frame_start.
- Frame start then 23 continuous valid pixels (default params) -> o_window_valid rises one cycle after the 23rd accept (x=2,y=2) with window (0,0). o_pixel_ready=0 until i_classify_done.
- Full 100-pixel frame with i_classify_done returned 3 cycles after each valid -> exactly 64 windows, last at (7,7). o_frame_done pulses once after the final done. o_mem_wen count = 100.
- i_classify_done held high during streaming, and i_pixel_valid=1 while o_pixel_ready=0 -> no spurious window completion and no extra mem writes. Pixel order into memory is preserved.
- i_frame_start with i_pixel_valid=1 mid-frame at (5,4) -> that pixel is not written, counters restart at (0,0) and the next accept writes pixel 0 of the new frame.
- WINDOW_STRIDE2_EN defined, full frame -> 16 windows, all with even coordinates; no stall on odd-coordinate windows.
